mem_port_arbiter: RTL and testbench

- Shares the single-port unified 16-bit memory between instruction fetch (p1) and the load/store port driven by execute (p4).
- Grants one access at a time and tracks fixed-latency read returns.
- Generates fetch/mem stall signals.
- Discards fetch data killed by a taken branch or jump.

---
 rtl/urisc_pkg.sv | 18 +
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter_lat_tracker.sv | 70 +++++++
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/urisc_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Imported by the interface, the arbiter top and the latency tracker.
package urisc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam logic [1:0] STORE_NONE = 2'b00;
  localparam int         DATA_W     = 16;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, load/store port, branch flush, stall outputs and
// the single-port memory bus. The slave modport belongs to the arbiter.
interface mem_port_arbiter_if;
  import urisc_pkg::*;

  logic              if_req_p1;
  logic [DATA_W-1:0] if_addr_p1;
  logic              if_gnt_p1;
  logic              if_rdata_valid_p1;
  logic [DATA_W-1:0] if_rdata_p1;

  logic              dm_req_p4;
  logic [1:0]        dm_store_p4;
  logic [DATA_W-1:0] dm_addr_p4;
  logic [DATA_W-1:0] dm_wdata_p4;
  logic              dm_gnt_p4;
  logic              dm_rdata_valid_p4;
  logic [DATA_W-1:0] dm_rdata_p4;

  logic              flush_p3;
  logic              stall_if;
  logic              stall_mem;

  logic              mem_en;
  logic [1:0]        mem_wr;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req_p1, if_addr_p1,
    input  dm_req_p4, dm_store_p4, dm_addr_p4, dm_wdata_p4,
    input  flush_p3, mem_rdata,
    output if_gnt_p1, if_rdata_valid_p1, if_rdata_p1,
    output dm_gnt_p4, dm_rdata_valid_p4, dm_rdata_p4,
    output stall_if, stall_mem,
    output mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output if_req_p1, if_addr_p1,
    output dm_req_p4, dm_store_p4, dm_addr_p4, dm_wdata_p4,
    output flush_p3, mem_rdata,
    input  if_gnt_p1, if_rdata_valid_p1, if_rdata_p1,
    input  dm_gnt_p4, dm_rdata_valid_p4, dm_rdata_p4,
    input  stall_if, stall_mem,
    input  mem_en, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_lat_tracker.sv
// Tracks the single outstanding memory access: latency countdown, owner,
// store flag, branch-kill flag and the registered read-return data.
module lat_tracker
  import urisc_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  owner_t            start_owner,
  input  logic              start_store,
  input  logic              busy,
  input  logic              flush,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              done,
  output logic              load_out,
  output logic              fetch_live,
  output logic              if_valid,
  output logic              dm_valid,
  output logic [DATA_W-1:0] rdata
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  logic [CNT_W-1:0] cnt;
  owner_t           owner;
  logic             store;
  logic             kill;

  // Terminal count is the cycle in which the memory drives valid read data.
  assign done       = busy && (cnt == '0);
  assign load_out   = busy && (owner == OWN_DM) && !store;
  assign fetch_live = busy && (owner == OWN_IF) && !kill && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      owner <= OWN_IF;
      store <= 1'b0;
      kill  <= 1'b0;
    end else if (start) begin
      cnt   <= CNT_W'(MEM_LAT);
      owner <= start_owner;
      store <= start_store;
      kill  <= 1'b0;
    end else if (busy) begin
      if (done) begin
        kill <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
        if ((owner == OWN_IF) && flush) kill <= 1'b1;
      end
    end
  end

  // Return stage: valid pulses and data register one cycle after terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      rdata    <= '0;
    end else begin
      if_valid <= done && (owner == OWN_IF) && !kill && !flush;
      dm_valid <= done && (owner == OWN_DM) && !store;
      if (done && !store) rdata <= mem_rdata;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified single-port memory between instruction fetch and the
// load/store unit, issuing one access at a time and generating pipeline stalls.
module mem_port_arbiter
  import urisc_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  arb_state_t        state;
  logic [STARVE_W-1:0] starve;
  logic              if_ok;
  logic              starve_hit;
  logic              gnt_if;
  logic              gnt_dm;
  logic              gnt_any;
  owner_t            start_owner;
  logic              start_store;
  logic              done;
  logic              load_out;
  logic              fetch_live;
  logic              if_valid;
  logic              dm_valid;
  logic [DATA_W-1:0] rdata;

  logic              mem_en_q;
  logic [1:0]        mem_wr_q;
  logic [DATA_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  // A flushed fetch address is stale, so fetch is not eligible that cycle.
  always_comb begin
    if_ok      = bus.if_req_p1 && !bus.flush_p3;
    starve_hit = (starve == STARVE_W'(STARVE_MAX));
    gnt_if     = 1'b0;
    gnt_dm     = 1'b0;
    if (!rst && (state == IDLE)) begin
      if (bus.dm_req_p4 && !(if_ok && starve_hit)) gnt_dm = 1'b1;
      else if (if_ok)                              gnt_if = 1'b1;
    end
  end

  assign gnt_any     = gnt_if || gnt_dm;
  assign start_owner = gnt_dm ? OWN_DM : OWN_IF;
  assign start_store = gnt_dm && (bus.dm_store_p4 != STORE_NONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (gnt_any) state <= BUSY;
        BUSY:    if (done)    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || gnt_if || !bus.if_req_p1) begin
      starve <= '0;
    end else if (gnt_dm && !starve_hit) begin
      starve <= starve + 1'b1;
    end
  end

  // Issue stage: the winner's request is registered onto the memory bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en_q    <= 1'b0;
      mem_wr_q    <= STORE_NONE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_en_q <= gnt_any;
      if (gnt_dm) begin
        mem_wr_q    <= bus.dm_store_p4;
        mem_addr_q  <= bus.dm_addr_p4;
        mem_wdata_q <= bus.dm_wdata_p4;
      end else if (gnt_if) begin
        mem_wr_q    <= STORE_NONE;
        mem_addr_q  <= bus.if_addr_p1;
        mem_wdata_q <= '0;
      end
    end
  end

  lat_tracker #(
    .MEM_LAT (MEM_LAT)
  ) u_tracker (
    .clk         (clk),
    .rst         (rst),
    .start       (gnt_any),
    .start_owner (start_owner),
    .start_store (start_store),
    .busy        (state == BUSY),
    .flush       (bus.flush_p3),
    .mem_rdata   (bus.mem_rdata),
    .done        (done),
    .load_out    (load_out),
    .fetch_live  (fetch_live),
    .if_valid    (if_valid),
    .dm_valid    (dm_valid),
    .rdata       (rdata)
  );

  assign bus.if_gnt_p1         = gnt_if;
  assign bus.dm_gnt_p4         = gnt_dm;
  assign bus.stall_mem         = !rst && ((bus.dm_req_p4 && !gnt_dm) || load_out);
  assign bus.stall_if          = !rst && ((bus.if_req_p1 && !gnt_if) || fetch_live);
  assign bus.mem_en            = mem_en_q;
  assign bus.mem_wr            = mem_wr_q;
  assign bus.mem_addr          = mem_addr_q;
  assign bus.mem_wdata         = mem_wdata_q;
  assign bus.if_rdata_valid_p1 = if_valid;
  assign bus.if_rdata_p1       = rdata;
  assign bus.dm_rdata_valid_p4 = dm_valid;
  assign bus.dm_rdata_p4       = rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run checked against a cycle-indexed
// reference model of the arbiter (MEM_LAT=2, STARVE_MAX=4).
module tb_mem_port_arbiter;
  import urisc_pkg::*;

  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req_p1   = 1'b0;
    bus.if_addr_p1  = '0;
    bus.dm_req_p4   = 1'b0;
    bus.dm_store_p4 = STORE_NONE;
    bus.dm_addr_p4  = '0;
    bus.dm_wdata_p4 = '0;
    bus.flush_p3    = 1'b0;
    bus.mem_rdata   = '0;
  endtask

  task automatic drain();
    idle_inputs();
    repeat (LAT + 3) next_cycle();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if ({bus.if_gnt_p1, bus.dm_gnt_p4, bus.if_rdata_valid_p1, bus.dm_rdata_valid_p4} !== 4'b0) begin n_err++; $display("FAIL reset_ctl got=%b want=0000", {bus.if_gnt_p1, bus.dm_gnt_p4, bus.if_rdata_valid_p1, bus.dm_rdata_valid_p4}); end
    n_vec++; if ({bus.stall_if, bus.stall_mem, bus.mem_en} !== 3'b0) begin n_err++; $display("FAIL reset_stall got=%b want=000", {bus.stall_if, bus.stall_mem, bus.mem_en}); end
    n_vec++; if (bus.mem_wr !== 2'b00 || bus.mem_addr !== 16'h0 || bus.mem_wdata !== 16'h0) begin n_err++; $display("FAIL reset_membus got wr=%h addr=%h wdata=%h want 0", bus.mem_wr, bus.mem_addr, bus.mem_wdata); end
    n_vec++; if (bus.if_rdata_p1 !== 16'h0 || bus.dm_rdata_p4 !== 16'h0) begin n_err++; $display("FAIL reset_rdata got if=%h dm=%h want 0", bus.if_rdata_p1, bus.dm_rdata_p4); end
    next_cycle();
  endtask

  task automatic test_fetch();
    bus.if_req_p1 = 1'b1; bus.if_addr_p1 = 16'h0010;
    @(negedge clk);
    n_vec++; if (bus.if_gnt_p1 !== 1'b1 || bus.stall_if !== 1'b0) begin n_err++; $display("FAIL fetch_gnt got gnt=%b stall=%b want 1/0", bus.if_gnt_p1, bus.stall_if); end
    next_cycle(); bus.if_req_p1 = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 16'h0010 || bus.mem_wr !== 2'b00) begin n_err++; $display("FAIL fetch_issue got en=%b addr=%h wr=%b want 1/0010/00", bus.mem_en, bus.mem_addr, bus.mem_wr); end
    n_vec++; if (bus.stall_if !== 1'b1) begin n_err++; $display("FAIL fetch_stall_t1 got=%b want=1", bus.stall_if); end
    next_cycle();
    @(negedge clk);
    n_vec++; if (bus.mem_en !== 1'b0 || bus.stall_if !== 1'b1) begin n_err++; $display("FAIL fetch_t2 got en=%b stall=%b want 0/1", bus.mem_en, bus.stall_if); end
    next_cycle(); bus.mem_rdata = 16'hABCD;
    @(negedge clk);
    n_vec++; if (bus.stall_if !== 1'b1 || bus.if_rdata_valid_p1 !== 1'b0) begin n_err++; $display("FAIL fetch_t3 got stall=%b valid=%b want 1/0", bus.stall_if, bus.if_rdata_valid_p1); end
    next_cycle(); bus.mem_rdata = 16'h0000;
    @(negedge clk);
    n_vec++; if (bus.if_rdata_valid_p1 !== 1'b1 || bus.if_rdata_p1 !== 16'hABCD) begin n_err++; $display("FAIL fetch_return got valid=%b data=%h want 1/abcd", bus.if_rdata_valid_p1, bus.if_rdata_p1); end
    n_vec++; if (bus.stall_if !== 1'b0 || bus.dm_rdata_valid_p4 !== 1'b0) begin n_err++; $display("FAIL fetch_t4 got stall=%b dmv=%b want 0/0", bus.stall_if, bus.dm_rdata_valid_p4); end
    next_cycle();
    @(negedge clk);
    n_vec++; if (bus.if_rdata_valid_p1 !== 1'b0) begin n_err++; $display("FAIL fetch_pulse got=%b want=0", bus.if_rdata_valid_p1); end
    drain();
  endtask

  task automatic test_starve();
    bit   got;
    logic exp_if;
    bus.if_req_p1 = 1'b1; bus.if_addr_p1 = 16'h0100;
    bus.dm_req_p4 = 1'b1; bus.dm_addr_p4 = 16'h0200; bus.dm_store_p4 = STORE_NONE;
    for (int k = 0; k < 6; k++) begin
      got = 1'b0;
      for (int w = 0; w < LAT + 4 && !got; w++) begin
        @(negedge clk);
        if (bus.if_gnt_p1 || bus.dm_gnt_p4) got = 1'b1;
        else next_cycle();
      end
      exp_if = (k == 4);
      n_vec++; if (!got || bus.if_gnt_p1 !== exp_if || bus.dm_gnt_p4 !== !exp_if) begin n_err++; $display("FAIL starve_arb k=%0d got if=%b dm=%b want if=%b dm=%b", k, bus.if_gnt_p1, bus.dm_gnt_p4, exp_if, !exp_if); end
      next_cycle();
      @(negedge clk);
      n_vec++; if (bus.mem_addr !== (exp_if ? 16'h0100 : 16'h0200)) begin n_err++; $display("FAIL starve_addr k=%0d got=%h want=%h", k, bus.mem_addr, exp_if ? 16'h0100 : 16'h0200); end
      next_cycle();
    end
    drain();
  endtask

  task automatic test_store();
    bus.dm_req_p4 = 1'b1; bus.dm_store_p4 = 2'b01; bus.dm_addr_p4 = 16'h0040; bus.dm_wdata_p4 = 16'h1234;
    @(negedge clk);
    n_vec++; if (bus.dm_gnt_p4 !== 1'b1) begin n_err++; $display("FAIL store_gnt got=%b want=1", bus.dm_gnt_p4); end
    next_cycle(); bus.dm_req_p4 = 1'b0; bus.dm_store_p4 = STORE_NONE;
    @(negedge clk);
    n_vec++; if (bus.mem_en !== 1'b1 || bus.mem_wr !== 2'b01 || bus.mem_wdata !== 16'h1234 || bus.mem_addr !== 16'h0040) begin n_err++; $display("FAIL store_issue got en=%b wr=%b wdata=%h addr=%h want 1/01/1234/0040", bus.mem_en, bus.mem_wr, bus.mem_wdata, bus.mem_addr); end
    n_vec++; if (bus.stall_mem !== 1'b0) begin n_err++; $display("FAIL store_nostall got=%b want=0", bus.stall_mem); end
    next_cycle();
    @(negedge clk);
    n_vec++; if (bus.dm_rdata_valid_p4 !== 1'b0) begin n_err++; $display("FAIL store_t2_valid got=%b want=0", bus.dm_rdata_valid_p4); end
    next_cycle(); bus.dm_req_p4 = 1'b1; bus.dm_addr_p4 = 16'h0044;
    @(negedge clk);
    n_vec++; if (bus.dm_gnt_p4 !== 1'b0 || bus.stall_mem !== 1'b1) begin n_err++; $display("FAIL store_t3 got gnt=%b stall=%b want 0/1", bus.dm_gnt_p4, bus.stall_mem); end
    next_cycle();
    @(negedge clk);
    n_vec++; if (bus.dm_gnt_p4 !== 1'b1 || bus.dm_rdata_valid_p4 !== 1'b0) begin n_err++; $display("FAIL store_t4 got gnt=%b valid=%b want 1/0", bus.dm_gnt_p4, bus.dm_rdata_valid_p4); end
    drain();
  endtask

  task automatic test_flush_fetch();
    bus.if_req_p1 = 1'b1; bus.if_addr_p1 = 16'h0020;
    @(negedge clk);
    n_vec++; if (bus.if_gnt_p1 !== 1'b1) begin n_err++; $display("FAIL flush_gnt got=%b want=1", bus.if_gnt_p1); end
    next_cycle(); bus.if_req_p1 = 1'b0;
    next_cycle(); bus.flush_p3 = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.stall_if !== 1'b0) begin n_err++; $display("FAIL flush_stall_t2 got=%b want=0", bus.stall_if); end
    next_cycle(); bus.flush_p3 = 1'b0; bus.mem_rdata = 16'h5555;
    @(negedge clk);
    n_vec++; if (bus.stall_if !== 1'b0) begin n_err++; $display("FAIL flush_stall_t3 got=%b want=0", bus.stall_if); end
    next_cycle(); bus.mem_rdata = 16'h0000; bus.if_req_p1 = 1'b1; bus.if_addr_p1 = 16'h0024;
    @(negedge clk);
    n_vec++; if (bus.if_rdata_valid_p1 !== 1'b0) begin n_err++; $display("FAIL flush_killed got valid=%b want=0", bus.if_rdata_valid_p1); end
    n_vec++; if (bus.if_gnt_p1 !== 1'b1) begin n_err++; $display("FAIL flush_regrant got=%b want=1", bus.if_gnt_p1); end
    drain();
  endtask

  task automatic test_flush_idle();
    bus.if_req_p1 = 1'b1; bus.if_addr_p1 = 16'h0030;
    bus.dm_req_p4 = 1'b1; bus.dm_addr_p4 = 16'h0080; bus.flush_p3 = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.dm_gnt_p4 !== 1'b1 || bus.if_gnt_p1 !== 1'b0) begin n_err++; $display("FAIL flush_idle got dm=%b if=%b want 1/0", bus.dm_gnt_p4, bus.if_gnt_p1); end
    n_vec++; if (bus.stall_if !== 1'b1) begin n_err++; $display("FAIL flush_idle_stall got=%b want=1", bus.stall_if); end
    next_cycle();
    drain();
  endtask

  task automatic test_reset_load();
    bus.dm_req_p4 = 1'b1; bus.dm_addr_p4 = 16'h0300;
    @(negedge clk);
    n_vec++; if (bus.dm_gnt_p4 !== 1'b1) begin n_err++; $display("FAIL rstld_gnt got=%b want=1", bus.dm_gnt_p4); end
    next_cycle(); bus.dm_req_p4 = 1'b0;
    next_cycle(); rst = 1'b1;
    next_cycle(); rst = 1'b0; bus.mem_rdata = 16'h7777;
    @(negedge clk);
    n_vec++; if ({bus.mem_en, bus.stall_mem, bus.stall_if, bus.dm_rdata_valid_p4} !== 4'b0) begin n_err++; $display("FAIL rstld_ctl got=%b want=0000", {bus.mem_en, bus.stall_mem, bus.stall_if, bus.dm_rdata_valid_p4}); end
    n_vec++; if (bus.mem_addr !== 16'h0 || bus.mem_wr !== 2'b00 || bus.dm_rdata_p4 !== 16'h0) begin n_err++; $display("FAIL rstld_data got addr=%h wr=%b rdata=%h want 0", bus.mem_addr, bus.mem_wr, bus.dm_rdata_p4); end
    next_cycle(); bus.mem_rdata = 16'h0000; bus.dm_req_p4 = 1'b1; bus.dm_addr_p4 = 16'h0304;
    @(negedge clk);
    n_vec++; if (bus.dm_rdata_valid_p4 !== 1'b0) begin n_err++; $display("FAIL rstld_late got valid=%b want=0", bus.dm_rdata_valid_p4); end
    n_vec++; if (bus.dm_gnt_p4 !== 1'b1) begin n_err++; $display("FAIL rstld_regrant got=%b want=1", bus.dm_gnt_p4); end
    next_cycle(); bus.dm_req_p4 = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 16'h0304) begin n_err++; $display("FAIL rstld_issue got en=%b addr=%h want 1/0304", bus.mem_en, bus.mem_addr); end
    drain();
  endtask

  // Reference model: one access in flight, identified by its grant cycle and
  // the absolute cycle in which the memory returns data.
  task automatic test_random(input int n);
    bit          act, own_if, st, kill, gi, gd, if_ok, e_sif, e_smem;
    int          ret, starve;
    logic        e_en, e_ifv, e_dmv;
    logic [1:0]  e_wr;
    logic [15:0] e_addr, e_wdata, e_rdata;
    idle_inputs();
    rst = 1'b1; next_cycle(); rst = 1'b0;
    act = 0; own_if = 0; st = 0; kill = 0; ret = 0; starve = 0;
    e_en = 0; e_ifv = 0; e_dmv = 0; e_wr = '0; e_addr = '0; e_wdata = '0; e_rdata = '0;
    for (int cyc = 0; cyc < n; cyc++) begin
      bus.if_req_p1   = ($urandom_range(0, 2) != 0);
      bus.if_addr_p1  = 16'($urandom);
      bus.dm_req_p4   = ($urandom_range(0, 2) == 0);
      bus.dm_store_p4 = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
      bus.dm_addr_p4  = 16'($urandom);
      bus.dm_wdata_p4 = 16'($urandom);
      bus.flush_p3    = ($urandom_range(0, 5) == 0);
      bus.mem_rdata   = 16'($urandom);
      rst             = ($urandom_range(0, 99) == 0);
      gi = 0; gd = 0;
      if_ok = bus.if_req_p1 && !bus.flush_p3;
      if (!rst && !act) begin
        if (bus.dm_req_p4 && if_ok) begin
          if (starve == SMAX) gi = 1; else gd = 1;
        end else begin
          gd = bus.dm_req_p4;
          gi = if_ok;
        end
      end
      e_sif  = !rst && ((bus.if_req_p1 && !gi) || (act && own_if && !kill && !bus.flush_p3));
      e_smem = !rst && ((bus.dm_req_p4 && !gd) || (act && !own_if && !st));
      @(negedge clk);
      n_vec++; if (bus.if_gnt_p1 !== gi) begin n_err++; $display("FAIL rnd_if_gnt cyc=%0d got=%b want=%b", cyc, bus.if_gnt_p1, gi); end
      n_vec++; if (bus.dm_gnt_p4 !== gd) begin n_err++; $display("FAIL rnd_dm_gnt cyc=%0d got=%b want=%b", cyc, bus.dm_gnt_p4, gd); end
      n_vec++; if (bus.stall_if !== e_sif) begin n_err++; $display("FAIL rnd_stall_if cyc=%0d got=%b want=%b", cyc, bus.stall_if, e_sif); end
      n_vec++; if (bus.stall_mem !== e_smem) begin n_err++; $display("FAIL rnd_stall_mem cyc=%0d got=%b want=%b", cyc, bus.stall_mem, e_smem); end
      n_vec++; if (bus.mem_en !== e_en) begin n_err++; $display("FAIL rnd_mem_en cyc=%0d got=%b want=%b", cyc, bus.mem_en, e_en); end
      n_vec++; if (bus.mem_wr !== e_wr) begin n_err++; $display("FAIL rnd_mem_wr cyc=%0d got=%b want=%b", cyc, bus.mem_wr, e_wr); end
      n_vec++; if (bus.mem_addr !== e_addr) begin n_err++; $display("FAIL rnd_mem_addr cyc=%0d got=%h want=%h", cyc, bus.mem_addr, e_addr); end
      n_vec++; if (bus.mem_wdata !== e_wdata) begin n_err++; $display("FAIL rnd_mem_wdata cyc=%0d got=%h want=%h", cyc, bus.mem_wdata, e_wdata); end
      n_vec++; if (bus.if_rdata_valid_p1 !== e_ifv) begin n_err++; $display("FAIL rnd_if_valid cyc=%0d got=%b want=%b", cyc, bus.if_rdata_valid_p1, e_ifv); end
      n_vec++; if (bus.dm_rdata_valid_p4 !== e_dmv) begin n_err++; $display("FAIL rnd_dm_valid cyc=%0d got=%b want=%b", cyc, bus.dm_rdata_valid_p4, e_dmv); end
      n_vec++; if (bus.if_rdata_p1 !== e_rdata) begin n_err++; $display("FAIL rnd_if_rdata cyc=%0d got=%h want=%h", cyc, bus.if_rdata_p1, e_rdata); end
      n_vec++; if (bus.dm_rdata_p4 !== e_rdata) begin n_err++; $display("FAIL rnd_dm_rdata cyc=%0d got=%h want=%h", cyc, bus.dm_rdata_p4, e_rdata); end
      if (rst) begin
        act = 0; kill = 0; starve = 0;
        e_en = 0; e_ifv = 0; e_dmv = 0; e_wr = '0; e_addr = '0; e_wdata = '0; e_rdata = '0;
      end else begin
        e_ifv = 0; e_dmv = 0;
        if (act && cyc == ret) begin
          e_ifv = own_if && !kill && !bus.flush_p3;
          e_dmv = !own_if && !st;
          if (!st) e_rdata = bus.mem_rdata;
          act = 0; kill = 0;
        end else if (act && own_if && bus.flush_p3) begin
          kill = 1;
        end
        e_en = gi || gd;
        if (gd) begin
          e_wr = bus.dm_store_p4; e_addr = bus.dm_addr_p4; e_wdata = bus.dm_wdata_p4;
        end else if (gi) begin
          e_wr = 2'b00; e_addr = bus.if_addr_p1; e_wdata = 16'h0;
        end
        if (gi || gd) begin
          act = 1; own_if = gi; st = gd && (bus.dm_store_p4 != 2'b00);
          ret = cyc + 1 + LAT; kill = 0;
        end
        if (gi || !bus.if_req_p1) starve = 0;
        else if (gd && starve < SMAX) starve++;
      end
      next_cycle();
    end
    rst = 1'b0;
    drain();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_fetch();
    test_starve();
    test_store();
    test_flush_fetch();
    test_flush_idle();
    test_reset_load();
    test_random(1500);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
